hyper_cdc_req_ack_ctrl: RTL and testbench

//  Source-side sequencer for a 4-phase req/ack multi-bit clock-domain crossing.

---
 rtl/hyper_cdc_req_ack_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hyper_cdc_req_ack_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hyper_cdc_req_ack_ctrl.sv
// hyper_cdc_req_ack_ctrl
// Source-side sequencer for a 4-phase req/ack multi-bit clock-domain crossing.
// A word accepted on the local valid/ready interface is held on data_o while
// req_o walks the remote domain through req-up / ack-up / req-down / ack-down.
// ack_i is brought into this domain through a SYNC_STAGES-deep flop chain, and
// an optional watchdog abandons a handshake that overstays its cycle budget.
module hyper_cdc_req_ack_ctrl #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             req_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ack_i,
    output logic             busy_o,
    output logic             timeout_o,
    input  logic             clr_timeout_i
);

    // Counter just wide enough to hold TIMEOUT; a 1-bit stub when the watchdog is off.
    localparam int unsigned      CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               WD_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_HIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_q, req_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic                   ack_s;
    logic                   accept_s;
    logic                   wd_hit_s;
    logic                   to_set_s;

    // State register plus every datapath flop; reset aborts any handshake in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            req_q     <= 1'b0;
            data_q    <= RESET_VALUE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            req_q     <= req_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Handshake qualifiers: synchronized ack, local accept, watchdog hit.
    always_comb begin
        ack_s      = sync_q[SYNC_STAGES-1];
        // A stale remote ack still high would be mistaken for the next word's ack.
        in_ready_o = (state_q == ST_IDLE) & ~ack_s;
        busy_o     = (state_q != ST_IDLE);
        accept_s   = in_valid_i & in_ready_o;
        wd_hit_s   = WD_EN & (cnt_q >= CNT_HIT);
    end

    // Next-state logic; a normal exit always takes priority over the watchdog.
    always_comb begin
        state_d  = state_q;
        to_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (ack_s) begin
                    state_d = ST_DROP;
                end else if (wd_hit_s) begin
                    state_d  = ST_IDLE;
                    to_set_s = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (!ack_s) begin
                    state_d = ST_IDLE;
                end else if (wd_hit_s) begin
                    state_d  = ST_IDLE;
                    to_set_s = 1'b1;
                end else begin
                    state_d = ST_DROP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values: req follows the next state, data only loads on accept.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], ack_i};
        req_d     = (state_d == ST_REQ);
        data_d    = data_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    data_d = in_data_i;
                    cnt_d  = '0;
                end else begin
                    data_d = data_q;
                    cnt_d  = cnt_q;
                end
            end
            ST_REQ, ST_DROP: begin
                // Saturate rather than wrap so a late exit can never re-arm the watchdog.
                if (WD_EN && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase

        // Sticky flag: a new timeout outranks a clear arriving in the same cycle.
        if (to_set_s) begin
            timeout_d = 1'b1;
        end else if (clr_timeout_i) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // All interface outputs except in_ready_o/busy_o come straight from flops.
    always_comb begin
        req_o     = req_q;
        data_o    = data_q;
        timeout_o = timeout_q;
    end

endmodule

// File: tb/tb_hyper_cdc_req_ack_ctrl.sv
// Self-checking bench for hyper_cdc_req_ack_ctrl (WIDTH=32, SYNC_STAGES=2, TIMEOUT=16).
// Directed vector table, hand-written corner sequences, then randomized traffic
// against a handshake-level reference model with a reactive remote responder.
module tb_hyper_cdc_req_ack_ctrl;

    localparam int SYNC = 2;
    localparam int TOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_data_i;
    logic        req_o;
    logic [31:0] data_o;
    logic        ack_i;
    logic        busy_o;
    logic        timeout_o;
    logic        clr_timeout_i;

    int checks   = 0;
    int failures = 0;

    hyper_cdc_req_ack_ctrl #(
        .WIDTH       (32),
        .SYNC_STAGES (SYNC),
        .RESET_VALUE (32'h0),
        .TIMEOUT     (TOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_data_i     (in_data_i),
        .req_o         (req_o),
        .data_o        (data_o),
        .ack_i         (ack_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o),
        .clr_timeout_i (clr_timeout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] din;
        logic        ack;
        logic        clr;
        logic        e_req;
        logic        e_rdy;
        logic        e_busy;
        logic        e_to;
        logic [31:0] e_data;
    } vec_t;

    vec_t vt[18];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        in_valid_i    = 1'b0;
        in_data_i     = 32'h0;
        clr_timeout_i = 1'b0;
        ack_i         = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- reference model (handshake level) ----------------
    bit          m_busy;
    bit          m_acked;
    bit          m_req;
    bit          m_to;
    logic [31:0] m_data;
    int          m_elapsed;
    bit          m_ackq[$];

    // Advance the model across one clock edge using the inputs currently driven.
    task automatic model_step();
        bit ack_seen;
        bit set_to;
        ack_seen = (m_ackq.size() > 0) ? m_ackq[0] : 1'b0;
        set_to   = 1'b0;
        if (rst) begin
            m_busy    = 1'b0;
            m_acked   = 1'b0;
            m_req     = 1'b0;
            m_to      = 1'b0;
            m_data    = 32'h0;
            m_elapsed = 0;
            m_ackq.delete();
            for (int i = 0; i < SYNC; i++) m_ackq.push_back(1'b0);
        end else begin
            if (!m_busy) begin
                if (in_valid_i && !ack_seen) begin
                    m_busy    = 1'b1;
                    m_acked   = 1'b0;
                    m_req     = 1'b1;
                    m_data    = in_data_i;
                    m_elapsed = 0;
                end
            end else begin
                if (!m_acked && ack_seen) begin
                    m_acked = 1'b1;
                    m_req   = 1'b0;
                end else if (m_acked && !ack_seen) begin
                    m_busy = 1'b0;
                end else if (m_elapsed >= TOUT - 1) begin
                    m_busy = 1'b0;
                    m_req  = 1'b0;
                    set_to = 1'b1;
                end
                m_elapsed++;
            end
            if (set_to) m_to = 1'b1;
            else if (clr_timeout_i) m_to = 1'b0;
            void'(m_ackq.pop_front());
            m_ackq.push_back(ack_i);
        end
    endtask

    task automatic model_compare(input int cyc);
        chk1 ($sformatf("rnd%0d_req", cyc),     req_o,      m_req);
        chk32($sformatf("rnd%0d_data", cyc),    data_o,     m_data);
        chk1 ($sformatf("rnd%0d_busy", cyc),    busy_o,     m_busy);
        chk1 ($sformatf("rnd%0d_ready", cyc),   in_ready_o, !m_busy && !m_ackq[0]);
        chk1 ($sformatf("rnd%0d_timeout", cyc), timeout_o,  m_to);
    endtask

    // Remote domain: echoes req_o on ack_i after a random delay.
    int r_cnt = 0;
    task automatic remote_next(input bit allow_long);
        if (req_o && !ack_i) begin
            if (r_cnt == 0) ack_i = 1'b1;
            else r_cnt--;
        end else if (!req_o && ack_i) begin
            if (r_cnt == 0) ack_i = 1'b0;
            else r_cnt--;
        end else begin
            if (allow_long && ($urandom_range(0, 9) == 0)) r_cnt = $urandom_range(13, 22);
            else r_cnt = $urandom_range(0, 4);
        end
    endtask

    logic [31:0] words[4];
    logic [31:0] held;
    int          n;
    int          widx;
    int          seen;
    bit          prev_req;
    bit          accepted;

    initial begin
        rst = 1'b1; in_valid_i = 1'b0; in_data_i = 32'h0; ack_i = 1'b0; clr_timeout_i = 1'b0;

        // rst  vld   din            ack   clr  | req   rdy   busy  to    data
        vt[0]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[4]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[6]  = '{1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        vt[7]  = '{1'b0, 1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[8]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[9]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[10] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[11] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[12] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[13] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[14] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A5_0001};
        vt[15] = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001};
        vt[16] = '{1'b0, 1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_1234};
        vt[17] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        // ---- vector table: reset with stale ack, single word, reset in REQ ----
        for (int i = 0; i < 18; i++) begin
            rst = vt[i].rst; in_valid_i = vt[i].vld; in_data_i = vt[i].din;
            ack_i = vt[i].ack; clr_timeout_i = vt[i].clr;
            tick();
            chk1 ($sformatf("vec%0d_req", i),     req_o,      vt[i].e_req);
            chk1 ($sformatf("vec%0d_ready", i),   in_ready_o, vt[i].e_rdy);
            chk1 ($sformatf("vec%0d_busy", i),    busy_o,     vt[i].e_busy);
            chk1 ($sformatf("vec%0d_timeout", i), timeout_o,  vt[i].e_to);
            chk32($sformatf("vec%0d_data", i),    data_o,     vt[i].e_data);
        end

        // ---- back-to-back: four words, valid held high, remote echoes next cycle ----
        do_reset();
        words[0] = 32'h1111_0001; words[1] = 32'h2222_0002;
        words[2] = 32'h3333_0003; words[3] = 32'h4444_0004;
        widx = 0; seen = 0; prev_req = 1'b0; held = 32'h0;
        for (int c = 0; c < 200 && seen < 4; c++) begin
            in_valid_i = (widx < 4);
            in_data_i  = words[(widx < 4) ? widx : 3];
            accepted   = in_valid_i && in_ready_o;
            tick();
            if (accepted) widx++;
            if (req_o && !prev_req) begin
                chk32($sformatf("b2b_word%0d", seen), data_o, words[seen]);
                held = data_o;
                seen++;
            end else if (req_o) begin
                chk32("b2b_stable", data_o, held);
            end
            prev_req = req_o;
            ack_i    = req_o;
        end
        in_valid_i = 1'b0;
        chk32("b2b_count", seen, 32'd4);

        // ---- watchdog: ack stuck low ----
        do_reset();
        in_valid_i = 1'b1; in_data_i = 32'hC0DE_0016;
        tick();
        in_valid_i = 1'b0;
        chk1("to_req_up", req_o, 1'b1);
        n = 0;
        while (req_o === 1'b1 && n < 40) begin
            tick();
            n++;
            chk32("to_data_stable", data_o, 32'hC0DE_0016);
        end
        chk32("to_req_cycles", n, 32'd16);
        chk1("to_flag", timeout_o, 1'b1);
        chk1("to_idle", busy_o, 1'b0);
        chk1("to_ready", in_ready_o, 1'b1);
        in_valid_i = 1'b1; in_data_i = 32'hC0DE_0017;
        tick();
        in_valid_i = 1'b0;
        chk1("to_next_req", req_o, 1'b1);
        chk32("to_next_data", data_o, 32'hC0DE_0017);
        chk1("to_sticky", timeout_o, 1'b1);
        clr_timeout_i = 1'b1;
        tick();
        chk1("to_cleared", timeout_o, 1'b0);
        n = 0;
        while (req_o === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk32("to_req_cycles2", n, 32'd15);
        chk1("to_set_beats_clr", timeout_o, 1'b1);
        tick();
        chk1("to_clr_after", timeout_o, 1'b0);
        clr_timeout_i = 1'b0;

        // ---- race: ack_s falls in DROP exactly on the watchdog-hit cycle ----
        do_reset();
        in_valid_i = 1'b1; in_data_i = 32'hBEEF_0006;
        tick();
        in_valid_i = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            ack_i = (k <= 13);
            tick();
            if (k == 2) chk1("race_req_up", req_o, 1'b1);
            if (k == 3) begin
                chk1("race_req_down", req_o, 1'b0);
                chk1("race_drop_busy", busy_o, 1'b1);
            end
            if (k == 15) chk1("race_still_drop", busy_o, 1'b1);
            if (k == 16) begin
                chk1("race_idle", busy_o, 1'b0);
                chk1("race_no_timeout", timeout_o, 1'b0);
                chk1("race_ready", in_ready_o, 1'b1);
            end
        end

        // ---- reset while in DROP ----
        do_reset();
        in_valid_i = 1'b1; in_data_i = 32'h5EED_0005;
        tick();
        in_valid_i = 1'b0;
        ack_i = 1'b1;
        tick(); tick(); tick();
        chk1("rstd_in_drop", busy_o, 1'b1);
        chk1("rstd_req_low", req_o, 1'b0);
        chk32("rstd_data_held", data_o, 32'h5EED_0005);
        rst = 1'b1;
        tick();
        chk1("rstd_idle", busy_o, 1'b0);
        chk1("rstd_req", req_o, 1'b0);
        chk32("rstd_data", data_o, 32'h0);
        chk1("rstd_ready", in_ready_o, 1'b1);
        rst = 1'b0; ack_i = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk1("rstd_no_spurious_req", req_o, 1'b0);
        chk1("rstd_no_spurious_busy", busy_o, 1'b0);

        // ---- randomized traffic against the reference model ----
        r_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst           = (cyc < 2) || ($urandom_range(0, 299) == 0);
            in_valid_i    = ($urandom_range(0, 9) < 6);
            in_data_i     = $urandom;
            clr_timeout_i = ($urandom_range(0, 19) == 0);
            model_step();
            tick();
            model_compare(cyc);
            remote_next(1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
